// File: rtl/regfile_arb_pkg.sv
// Shared types and default widths for the register-file write arbiter.
package regfile_arb_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin pick with a last-winner flag that only moves on update.
module rr_arb2 (
  input  logic clock,
  input  logic reset,
  input  logic req_a,
  input  logic req_b,
  input  logic update,
  output logic pick_b
);

  logic last_b;

  // B wins alone, or on a tie when A won last time.
  assign pick_b = req_b & (~req_a | ~last_b);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_b <= 1'b1;
    end else if (update) begin
      last_b <= pick_b;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Two-port write arbiter for a register file; all outputs are registered.
// Optional macro REGFILE_ARB_R0_PROTECT_EN suppresses the write enable for register 0.
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_a,
  input  logic                 req_b,
  input  logic [ADDR_W-1:0]    addr_a,
  input  logic [ADDR_W-1:0]    addr_b,
  input  logic [DATA_W-1:0]    data_a,
  input  logic [DATA_W-1:0]    data_b,
  output logic                 gnt_a,
  output logic                 gnt_b,
  output logic [2**ADDR_W-1:0] reg_we,
  output logic [DATA_W-1:0]    wdata,
  output logic                 busy
);

  localparam int NREG = 2**ADDR_W;

  state_t            state, state_nxt;
  logic              pick_b;
  logic              arb_update;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  logic [NREG-1:0]   win_we;
  logic              gnt_a_nxt, gnt_b_nxt, busy_nxt;
  logic [NREG-1:0]   reg_we_nxt;
  logic [DATA_W-1:0] wdata_nxt;

  rr_arb2 u_rr_arb2 (
    .clock  (clock),
    .reset  (reset),
    .req_a  (req_a),
    .req_b  (req_b),
    .update (arb_update),
    .pick_b (pick_b)
  );

  assign win_addr = pick_b ? addr_b : addr_a;
  assign win_data = pick_b ? data_b : data_a;

  // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    win_we           = '0;
    win_we[win_addr] = 1'b1;
`ifdef REGFILE_ARB_R0_PROTECT_EN
    if (win_addr == '0) win_we = '0;
`endif
  end

  always_comb begin
    state_nxt  = state;
    arb_update = 1'b0;
    gnt_a_nxt  = 1'b0;
    gnt_b_nxt  = 1'b0;
    busy_nxt   = 1'b0;
    reg_we_nxt = '0;
    wdata_nxt  = '0;
    case (state)
      ST_IDLE: begin
        if (req_a || req_b) begin
          state_nxt  = ST_WRITE;
          arb_update = 1'b1;
          gnt_a_nxt  = ~pick_b;
          gnt_b_nxt  = pick_b;
          busy_nxt   = 1'b1;
          reg_we_nxt = win_we;
          wdata_nxt  = win_data;
        end
      end
      // Requests are ignored here; the write lasts exactly one cycle.
      ST_WRITE: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= ST_IDLE;
      gnt_a  <= 1'b0;
      gnt_b  <= 1'b0;
      busy   <= 1'b0;
      reg_we <= '0;
      wdata  <= '0;
    end else begin
      state  <= state_nxt;
      gnt_a  <= gnt_a_nxt;
      gnt_b  <= gnt_b_nxt;
      busy   <= busy_nxt;
      reg_we <= reg_we_nxt;
      wdata  <= wdata_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed plus randomized bench for regfile_write_arbiter against a cycle-level reference model.
module tb_regfile_write_arbiter;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NR = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          req_a, req_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] data_a, data_b;
  logic          gnt_a, gnt_b, busy;
  logic [NR-1:0] reg_we;
  logic [DW-1:0] wdata;

  int checks = 0;
  int errors = 0;

  // Reference model: what the outputs must show in the cycle after each edge.
  bit            m_busy, m_gnt_a, m_gnt_b;
  bit            m_last_b;
  logic [NR-1:0] m_we;
  logic [DW-1:0] m_wdata;

  regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clock  (clock),
    .reset  (reset),
    .req_a  (req_a),
    .req_b  (req_b),
    .addr_a (addr_a),
    .addr_b (addr_b),
    .data_a (data_a),
    .data_b (data_b),
    .gnt_a  (gnt_a),
    .gnt_b  (gnt_b),
    .reg_we (reg_we),
    .wdata  (wdata),
    .busy   (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NR-1:0] we_for(input logic [AW-1:0] a);
    logic [NR-1:0] w;
    w = NR'(1) << a;
`ifdef REGFILE_ARB_R0_PROTECT_EN
    if (a == 0) w = '0;
`endif
    return w;
  endfunction

  // Advance the model from the current inputs, clock the DUT, then compare everything.
  task automatic tick(input string tag);
    bit win_b;
    if (reset) begin
      {m_busy, m_gnt_a, m_gnt_b} = '0;
      m_we = '0; m_wdata = '0; m_last_b = 1'b1;
    end else if (!m_busy && (req_a || req_b)) begin
      win_b    = (req_a && req_b) ? !m_last_b : req_b;
      m_last_b = win_b;
      m_busy   = 1'b1;
      m_gnt_a  = !win_b;
      m_gnt_b  = win_b;
      m_we     = we_for(win_b ? addr_b : addr_a);
      m_wdata  = win_b ? data_b : data_a;
    end else begin
      {m_busy, m_gnt_a, m_gnt_b} = '0;
      m_we = '0; m_wdata = '0;
    end
    @(posedge clock);
    #1;
    check({tag, ".gnt_a"},  gnt_a,  m_gnt_a);
    check({tag, ".gnt_b"},  gnt_b,  m_gnt_b);
    check({tag, ".busy"},   busy,   m_busy);
    check({tag, ".reg_we"}, reg_we, m_we);
    check({tag, ".wdata"},  wdata,  m_wdata);
    check({tag, ".excl"},   gnt_a & gnt_b, 1'b0);
  endtask

  initial begin
    int grants_a;
    int grants_b;
    reset = 1'b1; req_a = 1'b0; req_b = 1'b0;
    addr_a = '0; addr_b = '0; data_a = '0; data_b = '0;

    tick("reset0");
    tick("reset1");
    reset = 1'b0;
    tick("idle");

    // Single requester A, register 5.
    req_a = 1'b1; addr_a = 4'd5; data_a = 32'h0000_000F;
    tick("a5_write");
    check("a5_we_lit", reg_we, 16'h0020);
    check("a5_gnt_lit", {gnt_a, gnt_b, busy}, 3'b101);
    tick("a5_after");
    check("a5_clear_lit", {gnt_a, reg_we, wdata, busy}, '0);
    req_a = 1'b0;
    tick("a5_idle");

    // Both held: grants alternate, starting with B since A won last.
    req_a = 1'b1; addr_a = 4'd2; data_a = 32'hAAAA_0002;
    req_b = 1'b1; addr_b = 4'd3; data_b = 32'hBBBB_0003;
    grants_a = 0; grants_b = 0;
    for (int i = 0; i < 8; i++) begin
      tick("rr");
      if (i % 2 == 0) begin
        check("rr_alt", {gnt_a, gnt_b}, (i % 4 == 0) ? 2'b01 : 2'b10);
        grants_a += int'(gnt_a);
        grants_b += int'(gnt_b);
      end
    end
    check("rr_balance", 64'(grants_a), 64'(grants_b));
    req_a = 1'b0;
    tick("rr_drain");
    req_b = 1'b0;

    // B only, then reset during its write; the write is dropped and A is favoured afterwards.
    tick("pre_b7");
    req_b = 1'b1; addr_b = 4'd7; data_b = 32'h7777_7777;
    tick("b7_write");
    check("b7_we_lit", reg_we, 16'h0080);
    reset = 1'b1;
    tick("b7_abort");
    check("b7_abort_lit", {gnt_b, reg_we}, '0);
    reset = 1'b0; req_a = 1'b1; addr_a = 4'd1; data_a = 32'h1111_1111;
    tick("post_rst");
    check("post_rst_a_first", {gnt_a, gnt_b}, 2'b10);
    req_a = 1'b0;
    tick("post_rst2");
    tick("post_rst3");
    check("post_rst_b_next", {gnt_a, gnt_b}, 2'b01);
    req_b = 1'b0;
    tick("post_rst4");

    // Register 0.
    req_a = 1'b1; addr_a = 4'd0; data_a = 32'hF000_000F;
    tick("r0_write");
`ifdef REGFILE_ARB_R0_PROTECT_EN
    check("r0_we_lit", reg_we, 16'h0000);
`else
    check("r0_we_lit", reg_we, 16'h0001);
`endif
    check("r0_gnt_lit", gnt_a, 1'b1);
    req_a = 1'b0;
    tick("r0_after");

    // Address changes while busy do not affect the write in flight.
    req_a = 1'b1; addr_a = 4'd4; data_a = 32'h4444_4444;
    tick("chg_w4");
    addr_a = 4'd9; data_a = 32'h9999_9999;
    tick("chg_busy");
    tick("chg_w9");
    check("chg_we9_lit", reg_we, 16'h0200);
    req_a = 1'b0;
    tick("chg_done");

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      reset  = ($urandom_range(0, 31) == 0);
      req_a  = $urandom_range(0, 1) == 1;
      req_b  = $urandom_range(0, 1) == 1;
      addr_a = AW'($urandom);
      addr_b = AW'($urandom);
      data_a = $urandom;
      data_b = $urandom;
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 The module SHALL take parameter DATA_W, default 32, register data width.
REQ-002 The module SHALL take parameter ADDR_W, default 4, register address width; register count = 2**ADDR_W.
REQ-003 The module SHALL have port clock  input  1  single rising-edge clock.
REQ-004 The module SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The module SHALL have ports req_a / req_b  input  1  write request from requester A / B, level.
REQ-006 The module SHALL have ports addr_a / addr_b  input  ADDR_W  target register of A / B.
REQ-007 The module SHALL have ports data_a / data_b  input  DATA_W  write data of A / B.
REQ-008 The module SHALL have ports gnt_a / gnt_b  output  1  one-cycle grant, marks the request as consumed.
REQ-009 The module SHALL have port reg_we  output  2**ADDR_W  one-hot per-register write enable.
REQ-010 The module SHALL have port wdata  output  DATA_W  data broadcast to every register's data input.
REQ-011 The module SHALL have port busy  output  1  high while in WRITE.

Function
REQ-012 The module SHALL implement a two-state FSM: IDLE, WRITE.
REQ-013 In IDLE with neither request high, the FSM SHALL stay in IDLE, all outputs 0.
REQ-014 In IDLE with any request high, the FSM SHALL pick a winner, capture its addr/data into internal registers at the edge, and enter WRITE.
REQ-015 With only one request high, that requester SHALL win.
REQ-016 With both high, the requester not granted last SHALL win (round-robin); after reset, A SHALL be favoured.
REQ-017 WRITE SHALL last exactly one cycle: reg_we = one-hot of captured address, wdata = captured data, matching gnt_x = 1, busy = 1; then return to IDLE unconditionally.
REQ-018 In WRITE, request inputs SHALL be ignored; at most one gnt SHALL be high in any cycle.
REQ-019 Requesters SHALL hold req/addr/data stable until the edge ending their gnt cycle; they may re-request from the next cycle.
REQ-020 Latency: request seen at edge N -> register write enabled during cycle N..N+1 (outputs registered), register loads at edge N+1; peak throughput one write per two cycles.
REQ-021 Outputs SHALL come directly from flops; no combinational input-to-output path.
REQ-022 The last-winner flag SHALL update only on entry to WRITE.

Reset
REQ-023 While reset is high at an edge: state = IDLE, gnt_a = gnt_b = 0, reg_we = 0, wdata = 0, busy = 0, last-winner = B (so A is favoured next).
REQ-024 Reset asserted during WRITE SHALL abort the write: no reg_we after that edge, no grant, and the captured request is dropped (requester still high is re-arbitrated after reset).

Configuration
REQ-025 With REGFILE_ARB_R0_PROTECT_EN defined, a request to address 0 SHALL be granted normally but reg_we SHALL remain all-zero in its WRITE cycle.
REQ-026 Without REGFILE_ARB_R0_PROTECT_EN, address 0 SHALL be written like any other.

Structure
REQ-027 Package regfile_arb_pkg SHALL hold the FSM state enum and default DATA_W/ADDR_W constants.
REQ-028 The round-robin pick plus last-winner flop SHALL be a sub-module rr_arb2 (inputs req_a, req_b, update; output pick_b).

Verification
REQ-029 Only A requests, addr_a = 5, data_a = 32'h0000_000F -> next cycle gnt_a = 1, reg_we = 16'h0020, wdata = 32'h0000_000F, busy = 1; following cycle all 0.
REQ-030 A and B both held high, addr 2 / 3 -> grants alternate A, B, A, B every two cycles; never both gnt high.
REQ-031 Reset pulsed during a WRITE cycle for B (addr 7) -> reg_we = 0, gnt_b = 0 after that edge; state IDLE; with A and B both high afterwards, A granted first.
REQ-032 Request addr 0, data 32'hF000_000F -> gnt = 1 and reg_we = 16'h0001 without macro; gnt = 1 and reg_we = 0 with REGFILE_ARB_R0_PROTECT_EN.
REQ-033 Inputs changed while busy (addr_a 4 -> 9) after grant -> written address stays 4; new request 9 serviced in next WRITE.
